audio_dac_sched: RTL and testbench

Sample-rate scheduler and arbiter for the shared audio DAC serializer. It produces the sample-period tick, picks one of two sample FIFOs per tick, and issues the FIFO read. It then drives the DAC start/ready handshake with the fetched 32-bit stereo word (low half channel A, high half channel B). It sits between the AHB-fed sample FIFOs (e.g. floodcast stream and local alert stream) and the DAC writer, and replaces per-FIFO private pacing logic.

---
 rtl/audio_sched_pkg.sv | 22 ++
 rtl/audio_rate_tick.sv | 35 +++
 rtl/audio_dac_sched.sv | 150 +++++++++++++++
 tb/tb_audio_dac_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the audio DAC scheduler: FSM states, divider defaults, stats width.
// Pure declarations; no timing or flow control of its own.
package audio_sched_pkg;

    localparam int DEFAULT_DIV = 1360;
    localparam int MIN_DIV     = 8;
    localparam int CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAT1,
        LAT2,
        START,
        HOLD
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/audio_rate_tick.sv
// Sample-period divider: one-cycle tick every max(div_cfg, MIN_DIV)+1 cycles while enabled.
// Tick is combinational off the count register; no backpressure, period ignores downstream activity.
module audio_rate_tick #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = audio_sched_pkg::DEFAULT_DIV,
    parameter int MIN_DIV     = audio_sched_pkg::MIN_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // div_cfg is only looked at here, so a change lands on the next reload
    always_comb begin
        reload = (div_cfg < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_cfg;
    end

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= DIV_W'(DEFAULT_DIV);
        end else if (!enable || cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/audio_dac_sched.sv
// Paces and arbitrates two sample FIFOs onto the DAC: tick T -> re T+1 -> dac_data/dac_start from T+4.
// Waits in START/HOLD on dac_ready; ticks arriving mid-transaction are dropped (tick_miss). Stats: AUDIO_SCHED_STATS_EN.
module audio_dac_sched #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = audio_sched_pkg::DEFAULT_DIV,
    parameter int MIN_DIV     = audio_sched_pkg::MIN_DIV
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [1:0]       ch_en,
    input  logic             rr_mode,
    input  logic             empty0,
    input  logic             empty1,
    output logic             re0,
    output logic             re1,
    input  logic [31:0]      data0,
    input  logic [31:0]      data1,
    input  logic             dac_ready,
    output logic             dac_start,
    output logic [31:0]      dac_data,
    output logic [1:0]       grant,
    output logic             tick,
    output logic             underrun,
    output logic             tick_miss,
    output logic [15:0]      underrun_cnt,
    output logic [15:0]      miss_cnt
);

    import audio_sched_pkg::*;

    state_t state;
    logic   sel;
    logic   last;
    logic   cand0;
    logic   cand1;
    logic   pick1;

    audio_rate_tick #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .MIN_DIV     (MIN_DIV)
    ) u_rate (
        .clk     (HCLK),
        .rst     (HRESET),
        .enable  (enable),
        .div_cfg (div_cfg),
        .tick    (tick)
    );

    // last = 1 means ch1 was served most recently
    always_comb begin
        cand0 = ch_en[0] & ~empty0;
        cand1 = ch_en[1] & ~empty1;
        if (cand0 && cand1) begin
            pick1 = rr_mode ? ~last : 1'b0;
        end else begin
            pick1 = cand1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            grant     <= 2'b00;
            re0       <= 1'b0;
            re1       <= 1'b0;
            dac_start <= 1'b0;
            dac_data  <= '0;
            underrun  <= 1'b0;
            tick_miss <= 1'b0;
        end else begin
            re0       <= 1'b0;
            re1       <= 1'b0;
            underrun  <= 1'b0;
            tick_miss <= tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tick) begin
                        if (cand0 || cand1) begin
                            sel   <= pick1;
                            last  <= pick1;
                            grant <= pick1 ? 2'b10 : 2'b01;
                            re0   <= ~pick1;
                            re1   <= pick1;
                            state <= READ;
                        end else begin
                            underrun <= 1'b1;
                            grant    <= 2'b00;
                        end
                    end
                end
                READ: state <= LAT1;
                LAT1: state <= LAT2;
                LAT2: begin
                    dac_data <= sel ? data1 : data0;
                    // an already-idle writer gets the start together with the data
                    if (dac_ready) begin
                        dac_start <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        state     <= START;
                    end
                end
                START: begin
                    if (dac_ready) begin
                        dac_start <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!dac_ready) begin
                        dac_start <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AUDIO_SCHED_STATS_EN
    logic [CNT_W-1:0] und_q;
    logic [CNT_W-1:0] miss_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            und_q  <= '0;
            miss_q <= '0;
        end else begin
            if (underrun) begin
                und_q <= sat_inc(und_q);
            end
            if (tick_miss) begin
                miss_q <= sat_inc(miss_q);
            end
        end
    end

    assign underrun_cnt = und_q;
    assign miss_cnt     = miss_q;
`else
    assign underrun_cnt = '0;
    assign miss_cnt     = '0;
`endif

endmodule

// File: tb/tb_audio_dac_sched.sv
// Directed bench for audio_dac_sched with a two-stage FIFO read model and a DAC writer busy for 5 cycles per word.
module tb_audio_dac_sched;

`ifdef AUDIO_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        HCLK      = 1'b0;
    logic        HRESET    = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] div_cfg   = 16'd20;
    logic [1:0]  ch_en     = 2'b11;
    logic        rr_mode   = 1'b0;
    logic        empty0;
    logic        empty1;
    logic        re0;
    logic        re1;
    logic [31:0] data0     = '0;
    logic [31:0] data1     = '0;
    logic        dac_ready;
    logic        dac_start;
    logic [31:0] dac_data;
    logic [1:0]  grant;
    logic        tick;
    logic        underrun;
    logic        tick_miss;
    logic [15:0] underrun_cnt;
    logic [15:0] miss_cnt;

    audio_dac_sched dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .enable       (enable),
        .div_cfg      (div_cfg),
        .ch_en        (ch_en),
        .rr_mode      (rr_mode),
        .empty0       (empty0),
        .empty1       (empty1),
        .re0          (re0),
        .re1          (re1),
        .data0        (data0),
        .data1        (data1),
        .dac_ready    (dac_ready),
        .dac_start    (dac_start),
        .dac_data     (dac_data),
        .grant        (grant),
        .tick         (tick),
        .underrun     (underrun),
        .tick_miss    (tick_miss),
        .underrun_cnt (underrun_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // FIFO model: Q shows the popped word two edges after the RE cycle
    logic [31:0] mem0 [8];
    logic [31:0] mem1 [8];
    int          n0 = 0, n1 = 0, rd0 = 0, rd1 = 0;
    logic [31:0] p0 = '0, p1 = '0;

    assign empty0 = (rd0 >= n0);
    assign empty1 = (rd1 >= n1);

    always @(posedge HCLK) begin
        if (re0 === 1'b1 && rd0 < n0) begin
            p0  <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (re1 === 1'b1 && rd1 < n1) begin
            p1  <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
        data0 <= p0;
        data1 <= p1;
    end

    // DAC writer model: accepts on start&ready, then not ready for 5 cycles
    logic        dac_idle  = 1'b1;
    logic        dac_block = 1'b0;
    int          busy      = 0;
    logic [31:0] acc [16];
    int          acc_n     = 0;

    assign dac_ready = dac_idle && !dac_block;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dac_idle <= 1'b1;
            busy     <= 0;
        end else if (dac_idle) begin
            if (dac_start === 1'b1 && dac_ready) begin
                dac_idle   <= 1'b0;
                busy       <= 5;
                acc[acc_n] <= dac_data;
                acc_n      <= acc_n + 1;
            end
        end else begin
            busy <= busy - 1;
            if (busy == 1) dac_idle <= 1'b1;
        end
    end

    int n_re0 = 0, n_re1 = 0, n_und = 0, n_miss = 0, n_tick = 0;

    always @(posedge HCLK) begin
        if (re0 === 1'b1)       n_re0  <= n_re0 + 1;
        if (re1 === 1'b1)       n_re1  <= n_re1 + 1;
        if (underrun === 1'b1)  n_und  <= n_und + 1;
        if (tick_miss === 1'b1) n_miss <= n_miss + 1;
        if (tick === 1'b1)      n_tick <= n_tick + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_tick(input int limit, output int at);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (tick !== 1'b1 && k < limit);
        chk("tick_seen", {31'b0, tick}, 32'd1);
        at = cyc;
    endtask

    task automatic push0(input logic [31:0] v);
        mem0[n0] = v;
        n0++;
    endtask

    task automatic push1(input logic [31:0] v);
        mem1[n1] = v;
        n1++;
    endtask

    logic [1:0]  eg [4];
    logic [31:0] ed [4];
    int c0, t, t2, t3, snap_miss, snap_re0, snap_re1, snap_tick;

    initial begin
        #1 HRESET = 1'b1;
        #2;
        chk("rst_re0", {31'b0, re0}, 32'd0);
        chk("rst_re1", {31'b0, re1}, 32'd0);
        chk("rst_dac_start", {31'b0, dac_start}, 32'd0);
        chk("rst_tick", {31'b0, tick}, 32'd0);
        chk("rst_underrun", {31'b0, underrun}, 32'd0);
        chk("rst_tick_miss", {31'b0, tick_miss}, 32'd0);
        chk("rst_dac_data", dac_data, 32'd0);
        chk("rst_grant", {30'b0, grant}, 32'd0);
        chk("rst_underrun_cnt", {16'b0, underrun_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        step();
        HRESET = 1'b0;
        step();
        step();

        // Both FIFOs empty, div 20: underrun every 21 cycles, no reads
        enable = 1'b1;
        c0 = cyc;
        wait_tick(100, t);
        chk("first_tick_latency", t - c0, 32'd20);
        step();
        chk("underrun_pulse", {31'b0, underrun}, 32'd1);
        chk("grant_on_underrun", {30'b0, grant}, 32'd0);
        wait_tick(100, t2);
        chk("period_div20_a", t2 - t, 32'd21);
        wait_tick(100, t3);
        chk("period_div20_b", t3 - t2, 32'd21);
        step();
        step();
        chk("underrun_pulses", n_und, 32'd3);
        chk("underrun_cnt_3", {16'b0, underrun_cnt}, STATS ? 32'd3 : 32'd0);
        chk("no_re_when_empty", n_re0 + n_re1, 32'd0);
        enable = 1'b0;
        snap_tick = n_tick;
        repeat (30) step();
        chk("no_tick_disabled", n_tick - snap_tick, 32'd0);

        // Round robin over two loaded FIFOs
        rr_mode = 1'b1;
        push0(32'h0001_0001); push0(32'h0001_0002);
        push1(32'h0002_0001); push1(32'h0002_0002);
        eg[0] = 2'b01; ed[0] = 32'h0001_0001;
        eg[1] = 2'b10; ed[1] = 32'h0002_0001;
        eg[2] = 2'b01; ed[2] = 32'h0001_0002;
        eg[3] = 2'b10; ed[3] = 32'h0002_0002;
        step();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(100, t);
            step();
            chk("rr_grant", {30'b0, grant}, {30'b0, eg[i]});
            chk("rr_re0", {31'b0, re0}, {31'b0, eg[i][0]});
            chk("rr_re1", {31'b0, re1}, {31'b0, eg[i][1]});
            repeat (3) step();
            chk("rr_dac_data", dac_data, ed[i]);
            chk("rr_dac_start", {31'b0, dac_start}, 32'd1);
        end
        wait_tick(100, t);
        step();
        chk("rr_drained_underrun", {31'b0, underrun}, 32'd1);
        chk("rr_drained_grant", {30'b0, grant}, 32'd0);
        enable = 1'b0;
        repeat (12) step();
        chk("rr_acc0", acc[0], 32'h0001_0001);
        chk("rr_acc3", acc[3], 32'h0002_0002);
        chk("rr_re0_count", n_re0, 32'd2);
        chk("rr_re1_count", n_re1, 32'd2);

        // Fixed priority: ch0 drains before ch1 is touched
        rr_mode = 1'b0;
        push0(32'hA000_0001); push0(32'hA000_0002);
        push1(32'hB000_0001);
        eg[0] = 2'b01; ed[0] = 32'hA000_0001;
        eg[1] = 2'b01; ed[1] = 32'hA000_0002;
        eg[2] = 2'b10; ed[2] = 32'hB000_0001;
        step();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_tick(100, t);
            step();
            chk("fp_grant", {30'b0, grant}, {30'b0, eg[i]});
            repeat (3) step();
            chk("fp_dac_data", dac_data, ed[i]);
        end
        enable = 1'b0;
        repeat (12) step();
        chk("fp_re0_count", n_re0, 32'd4);
        chk("fp_re1_count", n_re1, 32'd3);

        // Stalled DAC with the minimum period: two ticks land in START
        div_cfg   = 16'd8;
        dac_block = 1'b1;
        push0(32'hC000_0001);
        snap_miss = n_miss;
        snap_re0  = n_re0;
        snap_re1  = n_re1;
        step();
        enable = 1'b1;
        c0 = cyc;
        repeat (8) step();
        chk("stall_tick0", {31'b0, tick}, 32'd1);
        step();
        chk("stall_re0", {31'b0, re0}, 32'd1);
        chk("stall_grant", {30'b0, grant}, 32'd1);
        repeat (3) step();
        chk("stall_no_start", {31'b0, dac_start}, 32'd0);
        repeat (5) step();
        chk("stall_tick1", {31'b0, tick}, 32'd1);
        step();
        chk("stall_tick_miss", {31'b0, tick_miss}, 32'd1);
        repeat (12) step();
        chk("stall_cycle30", cyc - c0, 32'd30);
        dac_block = 1'b0;
        step();
        chk("stall_start_late", {31'b0, dac_start}, 32'd1);
        step();
        step();
        chk("stall_start_drop", {31'b0, dac_start}, 32'd0);
        step();
        step();
        chk("stall_tick3", {31'b0, tick}, 32'd1);
        step();
        chk("stall_underrun", {31'b0, underrun}, 32'd1);
        chk("stall_no_miss_idle", {31'b0, tick_miss}, 32'd0);
        enable = 1'b0;
        step();
        chk("stall_miss_pulses", n_miss - snap_miss, 32'd2);
        chk("stall_miss_cnt", {16'b0, miss_cnt}, STATS ? 32'd2 : 32'd0);
        chk("stall_re0_once", n_re0 - snap_re0, 32'd1);
        chk("stall_re1_none", n_re1 - snap_re1, 32'd0);
        chk("stall_acc", acc[7], 32'hC000_0001);

        // div_cfg below the floor clamps to 8 -> 9-cycle period
        div_cfg = 16'd3;
        step();
        enable = 1'b1;
        c0 = cyc;
        wait_tick(100, t);
        chk("clamp_first", t - c0, 32'd8);
        wait_tick(100, t2);
        chk("clamp_period_a", t2 - t, 32'd9);
        wait_tick(100, t3);
        chk("clamp_period_b", t3 - t2, 32'd9);
        enable = 1'b0;

        // Reset landing in LAT2
        div_cfg = 16'd20;
        push0(32'hD000_0001);
        step();
        enable = 1'b1;
        wait_tick(100, t);
        step();
        chk("rst_tx_grant", {30'b0, grant}, 32'd1);
        step();
        step();
        chk("pre_reset_data", dac_data, 32'hC000_0001);
        #1 HRESET = 1'b1;
        #1;
        chk("async_dac_start", {31'b0, dac_start}, 32'd0);
        chk("async_re0", {31'b0, re0}, 32'd0);
        chk("async_dac_data", dac_data, 32'd0);
        chk("async_grant", {30'b0, grant}, 32'd0);
        chk("async_underrun_cnt", {16'b0, underrun_cnt}, 32'd0);
        step();
        HRESET = 1'b0;
        c0 = cyc;
        // the release cycle itself is the first of the DEFAULT_DIV+1
        wait_tick(1500, t);
        chk("post_reset_first_tick", t - c0, 32'd1360);
        step();
        chk("post_reset_underrun", {31'b0, underrun}, 32'd1);
        chk("post_reset_data", dac_data, 32'd0);
        enable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
